// File: rtl/mac_rx_head.sv
// mac_rx_head
// Front end of the Ethernet receive path. Strips the preamble/SFD, parses the
// 14-byte MAC header, filters on destination MAC and EtherType, and then streams
// payload bytes to the protocol demux. Frames that are not for this station or
// carry an unsupported EtherType are discarded with a one-cycle frm_drop pulse.
//
// Ports
//   clk      : single clock, all logic on the rising edge
//   rst      : synchronous, active-high reset
//   rx_dv    : PHY receive data valid
//   rxd      : PHY receive byte
//   mode     : captured EtherType for the demux (0 when no frame is active)
//   fs_mode  : payload-start flag, held until the demux returns fd_mode
//   fd_mode  : protocol-done flag from the demux
//   mode_rxd : registered payload byte (0 outside PAYLOAD)
//   src_mac  : source MAC of the most recently accepted frame
//   frm_drop : one-cycle pulse per discarded frame
module mac_rx_head #(
    parameter logic [47:0] LOCAL_MAC = 48'h000A3501FEC0,
    parameter logic [15:0] TIMEOUT   = 16'd1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_dv,
    input  logic [7:0]  rxd,
    output logic [15:0] mode,
    output logic        fs_mode,
    input  logic        fd_mode,
    output logic [7:0]  mode_rxd,
    output logic [47:0] src_mac,
    output logic        frm_drop
);

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        HEAD,
        PAYLOAD,
        WAIT,
        TAIL
    } state_t;

    state_t      state, state_n;
    logic [3:0]  hdr_cnt, hdr_cnt_n;
    logic [15:0] wait_cnt, wait_cnt_n;
    logic [39:0] hdr_sr, hdr_sr_n;
    logic [15:0] mode_n;
    logic        fs_n;
    logic [7:0]  rxd_n;
    logic [47:0] src_n;
    logic        drop_n;

    // The last five header bytes plus the byte currently on rxd form a complete
    // 48-bit field at header bytes 5 and 11, and the EtherType at byte 13, so
    // the full value can be committed in a single cycle.
    logic [47:0] hdr_word;
    logic [15:0] ether;
    logic        dst_ok;
    logic        ether_ok;

    assign hdr_word = {hdr_sr, rxd};
    assign ether    = hdr_word[15:0];
    assign dst_ok   = (hdr_word == LOCAL_MAC) || (hdr_word == 48'hFFFF_FFFF_FFFF);
    assign ether_ok = (ether == 16'h0800) || (ether == 16'h0806);

    always_comb begin
        state_n    = state;
        hdr_cnt_n  = hdr_cnt;
        wait_cnt_n = wait_cnt;
        hdr_sr_n   = hdr_sr;
        mode_n     = mode;
        fs_n       = 1'b0;
        rxd_n      = 8'h00;
        src_n      = src_mac;
        drop_n     = 1'b0;

        case (state)
            IDLE: begin
                if (rx_dv && rxd == 8'h55) begin
                    state_n = PRE;
                end
            end

            PRE: begin
                if (!rx_dv) begin
                    state_n = IDLE;
                end else if (rxd == 8'hD5) begin
                    state_n   = HEAD;
                    hdr_cnt_n = 4'd0;
                end else if (rxd != 8'h55) begin
                    state_n = IDLE;
                end
            end

            HEAD: begin
                if (!rx_dv) begin
                    // Truncated header: the frame is lost.
                    state_n = IDLE;
                    drop_n  = 1'b1;
                end else begin
                    hdr_sr_n  = hdr_word[39:0];
                    hdr_cnt_n = hdr_cnt + 4'd1;
                    if (hdr_cnt == 4'd5 && !dst_ok) begin
                        state_n = TAIL;
                        drop_n  = 1'b1;
                    end
                    if (hdr_cnt == 4'd11) begin
                        src_n = hdr_word;
                    end
                    if (hdr_cnt == 4'd13) begin
                        if (ether_ok) begin
                            mode_n  = ether;
                            state_n = PAYLOAD;
                        end else begin
                            mode_n  = 16'h0000;
                            state_n = TAIL;
                            drop_n  = 1'b1;
                        end
                    end
                end
            end

            PAYLOAD: begin
                // fd_mode wins over data: once the demux is done, any further
                // bytes (padding/FCS) are swallowed instead of forwarded.
                if (fd_mode) begin
                    state_n = rx_dv ? TAIL : IDLE;
                end else if (rx_dv) begin
                    rxd_n = rxd;
                    fs_n  = 1'b1;
                end else begin
                    state_n    = WAIT;
                    fs_n       = 1'b1;
                    wait_cnt_n = 16'd0;
                end
            end

            WAIT: begin
                if (fd_mode) begin
                    state_n = IDLE;
                end else if (wait_cnt == TIMEOUT - 16'd1) begin
                    state_n = IDLE;
                    drop_n  = 1'b1;
                end else begin
                    fs_n       = 1'b1;
                    wait_cnt_n = wait_cnt + 16'd1;
                end
            end

            TAIL: begin
                if (!rx_dv) begin
                    state_n = IDLE;
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase

        // No EtherType is ever presented while the receiver is idle.
        if (state_n == IDLE) begin
            mode_n = 16'h0000;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            hdr_cnt  <= 4'd0;
            wait_cnt <= 16'd0;
            hdr_sr   <= 40'd0;
            mode     <= 16'h0000;
            fs_mode  <= 1'b0;
            mode_rxd <= 8'h00;
            src_mac  <= 48'd0;
            frm_drop <= 1'b0;
        end else begin
            state    <= state_n;
            hdr_cnt  <= hdr_cnt_n;
            wait_cnt <= wait_cnt_n;
            hdr_sr   <= hdr_sr_n;
            mode     <= mode_n;
            fs_mode  <= fs_n;
            mode_rxd <= rxd_n;
            src_mac  <= src_n;
            frm_drop <= drop_n;
        end
    end

endmodule

// File: tb/tb_mac_rx_head.sv
// tb_mac_rx_head
// Self-checking bench for mac_rx_head. The driver describes each frame at the
// transaction level (destination, source, EtherType, payload length, how the
// demux finishes) and pushes the events the receiver must produce (payload
// start, each payload byte, end of fs_mode, drop pulses) with the cycle at which
// each must appear. A separate monitor pops and compares them as the DUT shows
// them, and also checks per-cycle invariants on mode and mode_rxd.
module tb_mac_rx_head;

    localparam logic [47:0] LOCAL = 48'h000A3501FEC0;
    localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;
    localparam int          TMO   = 40;

    localparam int F_WAIT  = 0;
    localparam int F_EARLY = 1;
    localparam int F_SIMUL = 2;
    localparam int F_TMO   = 3;

    localparam int EV_START = 0;
    localparam int EV_BYTE  = 1;
    localparam int EV_END   = 2;
    localparam int EV_DROP  = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_dv;
    logic [7:0]  rxd;
    logic [15:0] mode;
    logic        fs_mode;
    logic        fd_mode;
    logic [7:0]  mode_rxd;
    logic [47:0] src_mac;
    logic        frm_drop;

    mac_rx_head #(
        .LOCAL_MAC(LOCAL),
        .TIMEOUT  (16'(TMO))
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .rx_dv   (rx_dv),
        .rxd     (rxd),
        .mode    (mode),
        .fs_mode (fs_mode),
        .fd_mode (fd_mode),
        .mode_rxd(mode_rxd),
        .src_mac (src_mac),
        .frm_drop(frm_drop)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int          kind;
        logic [7:0]  data;
        logic [15:0] mode;
        logic [47:0] src;
        int          cyc;
    } evt_t;

    typedef struct {
        int          pre;
        logic [47:0] dst;
        logic [47:0] src;
        logic [15:0] etype;
        int          len;
        int          fin;
        int          arg;
    } frame_t;

    evt_t        exp_q[$];
    logic [15:0] allowed_mode = 16'h0000;
    logic [47:0] last_src     = 48'd0;
    logic        prev_fs      = 1'b0;

    function automatic void pushEvt(input int k, input logic [7:0] d, input logic [15:0] m,
                                    input logic [47:0] s, input int c);
        evt_t e;
        e.kind = k; e.data = d; e.mode = m; e.src = s; e.cyc = c;
        exp_q.push_back(e);
    endfunction

    function automatic frame_t mkFrame(input int pre, input logic [47:0] dst, input logic [47:0] src,
                                       input logic [15:0] et, input int len, input int fin, input int arg);
        frame_t f;
        f.pre = pre; f.dst = dst; f.src = src; f.etype = et; f.len = len; f.fin = fin; f.arg = arg;
        return f;
    endfunction

    task automatic popCheck(input int k);
        evt_t e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("[TB] FAIL event_unexpected: got kind=%0d cyc=%0d data=%h mode=%h src=%h, required no event",
                     k, cyc, mode_rxd, mode, src_mac);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.cyc != cyc || e.data != mode_rxd || e.mode != mode || e.src != src_mac) begin
                bad++;
                $display("[TB] FAIL event_k%0d: got kind=%0d cyc=%0d data=%h mode=%h src=%h, required kind=%0d cyc=%0d data=%h mode=%h src=%h",
                         e.kind, k, cyc, mode_rxd, mode, src_mac, e.kind, e.cyc, e.data, e.mode, e.src);
            end
        end
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rst) begin
            prev_fs = 1'b0;
        end else begin
            total++;
            if (!fs_mode && mode_rxd != 8'h00) begin
                bad++;
                $display("[TB] FAIL idle_rxd: got mode_rxd=%h at cyc=%0d, required 00", mode_rxd, cyc);
            end
            total++;
            if (mode != 16'h0000 && mode != allowed_mode) begin
                bad++;
                $display("[TB] FAIL mode_value: got mode=%h at cyc=%0d, required 0000 or %h", mode, cyc, allowed_mode);
            end
            if (fs_mode && !prev_fs)          popCheck(EV_START);
            if (fs_mode && mode_rxd != 8'h00) popCheck(EV_BYTE);
            if (!fs_mode && prev_fs)          popCheck(EV_END);
            if (frm_drop)                     popCheck(EV_DROP);
            prev_fs = fs_mode;
        end
    end

    // Drive one byte; c is the cycle at which its effect is visible on outputs.
    task automatic driveByte(input logic dv, input logic [7:0] b, input logic fd, output int c);
        @(posedge clk);
        #1;
        rx_dv   = dv;
        rxd     = b;
        fd_mode = fd;
        c       = cyc + 1;
    endtask

    task automatic checkOutput(input string name, input logic [15:0] m, input logic fs,
                               input logic [7:0] d, input logic [47:0] s, input logic dr);
        total++;
        if (mode != m || fs_mode != fs || mode_rxd != d || src_mac != s || frm_drop != dr) begin
            bad++;
            $display("[TB] FAIL %s: got mode=%h fs=%b rxd=%h src=%h drop=%b, required mode=%h fs=%b rxd=%h src=%h drop=%b",
                     name, mode, fs_mode, mode_rxd, src_mac, frm_drop, m, fs, d, s, dr);
        end
    endtask

    task automatic applyStimulus(input frame_t f);
        int          c;
        int          c0;
        logic [7:0]  hb[14];
        logic [7:0]  b;
        logic        dst_ok;
        logic        type_ok;
        bit          done;
        dst_ok  = (f.dst == LOCAL) || (f.dst == BCAST);
        type_ok = (f.etype == 16'h0800) || (f.etype == 16'h0806);
        allowed_mode = (dst_ok && type_ok) ? f.etype : 16'h0000;
        for (int i = 0; i < 6; i++) begin
            hb[i]     = f.dst[47 - 8*i -: 8];
            hb[6 + i] = f.src[47 - 8*i -: 8];
        end
        hb[12] = f.etype[15:8];
        hb[13] = f.etype[7:0];

        for (int i = 0; i < f.pre; i++) driveByte(1'b1, 8'h55, 1'b0, c);
        driveByte(1'b1, 8'hD5, 1'b0, c);
        for (int i = 0; i < 14; i++) begin
            driveByte(1'b1, hb[i], 1'b0, c);
            if (i == 5 && !dst_ok)             pushEvt(EV_DROP, 8'h00, 16'h0000, last_src, c);
            if (i == 11 && dst_ok)             last_src = f.src;
            if (i == 13 && dst_ok && !type_ok) pushEvt(EV_DROP, 8'h00, 16'h0000, last_src, c);
        end

        if (!(dst_ok && type_ok)) begin
            for (int j = 0; j < f.len; j++) driveByte(1'b1, 8'($urandom), 1'b0, c);
            driveByte(1'b0, 8'h00, 1'b0, c);
        end else begin
            done = 1'b0;
            for (int j = 0; j < f.len; j++) begin
                b = 8'($urandom_range(1, 255));
                if (!done && f.fin == F_EARLY && j == f.arg) begin
                    driveByte(1'b1, b, 1'b1, c);
                    pushEvt(EV_END, 8'h00, f.etype, f.src, c);
                    done = 1'b1;
                end else begin
                    driveByte(1'b1, b, 1'b0, c);
                    if (!done) begin
                        if (j == 0) pushEvt(EV_START, b, f.etype, f.src, c);
                        pushEvt(EV_BYTE, b, f.etype, f.src, c);
                    end
                end
            end
            case (f.fin)
                F_EARLY: driveByte(1'b0, 8'h00, 1'b0, c);
                F_SIMUL: begin
                    driveByte(1'b0, 8'h00, 1'b1, c);
                    pushEvt(EV_END, 8'h00, 16'h0000, f.src, c);
                end
                F_WAIT: begin
                    driveByte(1'b0, 8'h00, 1'b0, c0);
                    for (int k = 1; k < f.arg; k++) driveByte(1'b0, 8'h00, 1'b0, c);
                    driveByte(1'b0, 8'h00, 1'b1, c);
                    pushEvt(EV_END, 8'h00, 16'h0000, f.src, c);
                end
                default: begin
                    driveByte(1'b0, 8'h00, 1'b0, c0);
                    pushEvt(EV_END,  8'h00, 16'h0000, f.src, c0 + TMO);
                    pushEvt(EV_DROP, 8'h00, 16'h0000, f.src, c0 + TMO);
                    repeat (TMO + 1) driveByte(1'b0, 8'h00, 1'b0, c);
                end
            endcase
        end
        repeat (2 + $urandom_range(0, 3)) driveByte(1'b0, 8'h00, 1'b0, c);
    endtask

    task automatic applyTruncated();
        int c;
        allowed_mode = 16'h0000;
        repeat (7) driveByte(1'b1, 8'h55, 1'b0, c);
        driveByte(1'b1, 8'hD5, 1'b0, c);
        for (int i = 0; i < 4; i++) driveByte(1'b1, LOCAL[47 - 8*i -: 8], 1'b0, c);
        driveByte(1'b0, 8'h00, 1'b0, c);
        pushEvt(EV_DROP, 8'h00, 16'h0000, last_src, c);
        repeat (3) driveByte(1'b0, 8'h00, 1'b0, c);
    endtask

    initial begin
        #300000;
        bad++;
        $display("[TB] FAIL watchdog: got simulation still running at cyc=%0d, required completion", cyc);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        frame_t       f;
        int           c;
        int           r;
        logic [47:0]  d;
        logic [15:0]  et;
        int           len;
        int           fin;
        int           arg;
        logic [47:0]  s035;
        s035 = 48'h112233445566;

        rst = 1'b1; rx_dv = 1'b0; rxd = 8'h00; fd_mode = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_state", 16'h0000, 1'b0, 8'h00, 48'd0, 1'b0);
        rst = 1'b0;
        repeat (2) driveByte(1'b0, 8'h00, 1'b0, c);

        $display("[TB] directed frames");
        applyStimulus(mkFrame(7, LOCAL, s035, 16'h0800, 46, F_WAIT, 3));
        applyStimulus(mkFrame(7, BCAST, 48'hA1B2C3D4E5F6, 16'h0806, 46, F_EARLY, 28));
        applyStimulus(mkFrame(7, 48'h001122334455, 48'h0102030405AA, 16'h0800, 46, F_WAIT, 2));
        applyStimulus(mkFrame(7, LOCAL, 48'hCAFE00BEEF01, 16'h86DD, 20, F_WAIT, 1));
        applyStimulus(mkFrame(7, LOCAL, 48'h5A5A5A5A5A5A, 16'h0800, 30, F_TMO, 0));
        applyStimulus(mkFrame(2, BCAST, 48'h0F0E0D0C0B0A, 16'h0800, 10, F_SIMUL, 0));
        applyStimulus(mkFrame(1, LOCAL, 48'h998877665544, 16'h0806, 5, F_WAIT, 6));
        applyTruncated();

        // Preamble broken by a foreign byte: silently back to idle.
        allowed_mode = 16'h0000;
        driveByte(1'b1, 8'h55, 1'b0, c);
        driveByte(1'b1, 8'h55, 1'b0, c);
        driveByte(1'b1, 8'h12, 1'b0, c);
        driveByte(1'b1, 8'hD5, 1'b0, c);
        repeat (3) driveByte(1'b0, 8'h00, 1'b0, c);
        checkOutput("pre_abort", 16'h0000, 1'b0, 8'h00, last_src, 1'b0);

        // Reset in the middle of header byte 8, then a normal frame.
        allowed_mode = 16'h0000;
        repeat (7) driveByte(1'b1, 8'h55, 1'b0, c);
        driveByte(1'b1, 8'hD5, 1'b0, c);
        for (int i = 0; i < 6; i++) driveByte(1'b1, LOCAL[47 - 8*i -: 8], 1'b0, c);
        for (int i = 0; i < 3; i++) driveByte(1'b1, s035[47 - 8*i -: 8], 1'b0, c);
        @(posedge clk);
        #1;
        rst = 1'b1;
        rxd = s035[23:16];
        @(posedge clk);
        #1;
        rst   = 1'b0;
        rx_dv = 1'b0;
        rxd   = 8'h00;
        checkOutput("after_reset", 16'h0000, 1'b0, 8'h00, 48'd0, 1'b0);
        last_src = 48'd0;
        repeat (2) driveByte(1'b0, 8'h00, 1'b0, c);
        applyStimulus(mkFrame(7, LOCAL, s035, 16'h0800, 46, F_WAIT, 3));
        checkOutput("post_reset_frame", 16'h0000, 1'b0, 8'h00, s035, 1'b0);

        $display("[TB] random frames");
        for (int n = 0; n < 30; n++) begin
            r = $urandom_range(0, 3);
            d = (r < 2) ? LOCAL : (r == 2) ? BCAST : {16'($urandom), 32'($urandom)};
            r = $urandom_range(0, 4);
            et = (r < 2) ? 16'h0800 : (r == 2) ? 16'h0806 : (r == 3) ? 16'h86DD : 16'($urandom);
            len = $urandom_range(2, 50);
            fin = $urandom_range(0, 3);
            arg = (fin == F_WAIT) ? $urandom_range(1, 6) : (fin == F_EARLY) ? $urandom_range(1, len - 1) : 0;
            f = mkFrame($urandom_range(1, 7), d, {16'($urandom), 32'($urandom)}, et, len, fin, arg);
            applyStimulus(f);
        end

        for (int w = 0; w < 200 && exp_q.size() != 0; w++) @(posedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("[TB] FAIL pending_events: got %0d outstanding, required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mac_rx_head.md
MAC_RX_HEAD -- requirements
Module: mac_rx_head

Interface
REQ-001 SHALL have parameter LOCAL_MAC, default 48'h000A3501FEC0, station MAC address accepted as destination.
REQ-002 SHALL have parameter TIMEOUT, default 16'd1024, the maximum number of cycles spent in WAIT for fd_mode.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port rx_dv, input, 1 bit: PHY receive data valid.
REQ-006 SHALL have port rxd, input, 8 bits: PHY receive byte.
REQ-007 SHALL have port mode, output, 16 bits: captured EtherType routed to the protocol demux.
REQ-008 SHALL have port fs_mode, output, 1 bit: payload-start flag to the demux, held until done.
REQ-009 SHALL have port fd_mode, input, 1 bit: protocol-done flag returned from the demux.
REQ-010 SHALL have port mode_rxd, output, 8 bits: registered payload byte.
REQ-011 SHALL have port src_mac, output, 48 bits: source MAC of the current frame.
REQ-012 SHALL have port frm_drop, output, 1 bit: one-cycle pulse per discarded frame.

Function
REQ-013 SHALL implement states IDLE, PRE, HEAD, PAYLOAD, WAIT and TAIL.
REQ-014 In IDLE, SHALL go to PRE on rx_dv=1 with rxd=8'h55; otherwise SHALL stay in IDLE.
REQ-015 In PRE, SHALL stay on rxd=8'h55, go to HEAD on rxd=8'hD5, and go to IDLE on any other byte or on rx_dv=0, with no frm_drop.
REQ-016 In HEAD, SHALL count header bytes 0..13 with a 4-bit counter: bytes 0-5 are destination MAC, 6-11 source MAC and 12-13 EtherType, MSB first.
REQ-017 After byte 5, SHALL go to TAIL with a frm_drop pulse if the destination is neither LOCAL_MAC nor 48'hFFFFFFFFFFFF.
REQ-018 src_mac SHALL update only after byte 11 of an accepted destination.
REQ-019 After byte 13, SHALL load mode with the full EtherType in one cycle; no partial value is ever visible on mode.
REQ-020 If the EtherType is 16'h0800 or 16'h0806, SHALL go to PAYLOAD; otherwise SHALL go to TAIL with a frm_drop pulse and set mode to 0.
REQ-021 In PAYLOAD with rx_dv=1, mode_rxd SHALL equal rxd delayed one cycle; the first payload byte SHALL appear on mode_rxd in the same cycle fs_mode first rises.
REQ-022 fs_mode SHALL be 1 from the first payload cycle through PAYLOAD and WAIT until fd_mode is sampled 1, and 0 in every other state.
REQ-023 In PAYLOAD, on rx_dv=0, SHALL go to WAIT with mode_rxd=0.
REQ-024 In PAYLOAD, on fd_mode=1 (early finish, e.g. ARP plus padding/FCS), SHALL clear fs_mode next cycle and go to TAIL with no frm_drop.
REQ-025 If fd_mode=1 and rx_dv=0 in the same PAYLOAD cycle, SHALL go directly to IDLE with no frm_drop.
REQ-026 In WAIT, on fd_mode=1, SHALL go to IDLE.
REQ-027 In WAIT, the wait counter SHALL clear on entry; when it reaches TIMEOUT-1 without fd_mode, SHALL go to IDLE with a frm_drop pulse.
REQ-028 In TAIL, SHALL discard bytes with mode_rxd=0 until rx_dv=0, then go to IDLE.
REQ-029 In HEAD, on rx_dv=0, SHALL go to IDLE with a frm_drop pulse.
REQ-030 On every entry to IDLE, SHALL clear mode to 16'h0000; src_mac SHALL hold its value.
REQ-031 mode_rxd SHALL be 0 in every state except PAYLOAD.
REQ-032 Every output SHALL be registered.

Reset
REQ-033 When rst=1 at a clock edge, SHALL enter IDLE and set mode=0, fs_mode=0, mode_rxd=0, src_mac=0, frm_drop=0, and both counters to 0.
REQ-034 Reset SHALL take priority over all transitions, including mid-frame; the next frame after reset SHALL be accepted normally.

Verification
REQ-035 Scenario: 7x55,D5, dst=LOCAL_MAC, src=11..66, type 0800, 46-byte payload, fd_mode raised 3 cycles after rx_dv falls -> mode=0800, src_mac=112233445566, payload on mode_rxd in order, fs_mode high until fd_mode, then IDLE with mode=0.
REQ-036 Scenario: broadcast dst, type 0806, fd_mode raised after payload byte 28 while rx_dv is still high -> fs_mode falls, remaining bytes give mode_rxd=0, no frm_drop.
REQ-037 Scenario: dst=001122334455 -> frm_drop pulses once after byte 5, fs_mode never rises, mode stays 0.
REQ-038 Scenario: type 86DD -> frm_drop pulses once, mode=0, fs_mode stays 0.
REQ-039 Scenario: valid IP frame, fd_mode never asserted -> after TIMEOUT cycles in WAIT, frm_drop pulses, fs_mode=0, state IDLE.
REQ-040 Scenario: rst=1 during header byte 8, then a valid frame -> all outputs 0 on the following cycle, and the next frame is received per REQ-035.
